// File: rtl/missile_move_ctrl.sv
// rtl/missile_move_ctrl.sv - tank missile flight/explosion controller, IDLE/FLYING/EXPLODE FSM.
// Optional re-fire lockout enabled by defining MISSILE_COOLDOWN_EN.
module missile_move_ctrl #(
  parameter int SPEED           = 4,
  parameter int TANK_SIZE       = 32,
  parameter int MISSILE_W       = 8,
  parameter int MISSILE_H       = 8,
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479,
  parameter int EXPLODE_FRAMES  = 8,
  parameter int COOLDOWN_FRAMES = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic [10:0] tankX,
  input  logic [10:0] tankY,
  input  logic [1:0]  tankDir,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  dir,
  output logic        active,
  output logic        explode
);

  typedef enum logic [1:0] {IDLE, FLYING, EXPLODE} state_t;

  localparam int CW = $clog2(EXPLODE_FRAMES + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(EXPLODE_FRAMES - 1);

  localparam logic signed [11:0] TS_S   = 12'(TANK_SIZE);
  localparam logic signed [11:0] MW_S   = 12'(MISSILE_W);
  localparam logic signed [11:0] MH_S   = 12'(MISSILE_H);
  localparam logic signed [11:0] SP_S   = 12'(SPEED);
  localparam logic signed [11:0] OFFX_S = 12'(TANK_SIZE / 2 - MISSILE_W / 2);
  localparam logic signed [11:0] OFFY_S = 12'(TANK_SIZE / 2 - MISSILE_H / 2);
  localparam logic signed [12:0] XE_OFF = 13'(MISSILE_W - 1);
  localparam logic signed [12:0] YE_OFF = 13'(MISSILE_H - 1);
  localparam logic signed [12:0] XM_S   = 13'(X_MAX);
  localparam logic signed [12:0] YM_S   = 13'(Y_MAX);

  state_t        state_q;
  logic [10:0]   pos_x_q, pos_y_q;
  logic [1:0]    dir_q;
  logic          active_q, explode_q;
  logic [CW-1:0] frame_cnt_q;

  logic signed [11:0] tank_x_s, tank_y_s;
  logic signed [11:0] spawn_x, spawn_y, move_x, move_y;
  logic               spawn_ok, move_ok, fire_ok;

  // Bracket end is computed one bit wider so a large x cannot wrap back into range.
  function automatic logic in_bounds(input logic signed [11:0] x, input logic signed [11:0] y);
    logic signed [12:0] x_end;
    logic signed [12:0] y_end;
    x_end = {x[11], x} + XE_OFF;
    y_end = {y[11], y} + YE_OFF;
    return !x[11] && !y[11] && (x_end <= XM_S) && (y_end <= YM_S);
  endfunction

  always_comb begin
    tank_x_s = $signed({1'b0, tankX});
    tank_y_s = $signed({1'b0, tankY});
    spawn_x  = tank_x_s + OFFX_S;
    spawn_y  = tank_y_s - MH_S;
    case (tankDir)
      2'b00: begin spawn_x = tank_x_s + OFFX_S; spawn_y = tank_y_s - MH_S;   end
      2'b01: begin spawn_x = tank_x_s + TS_S;   spawn_y = tank_y_s + OFFY_S; end
      2'b10: begin spawn_x = tank_x_s + OFFX_S; spawn_y = tank_y_s + TS_S;   end
      default: begin spawn_x = tank_x_s - MW_S; spawn_y = tank_y_s + OFFY_S; end
    endcase
    spawn_ok = in_bounds(spawn_x, spawn_y);
  end

  always_comb begin
    move_x = $signed({1'b0, pos_x_q});
    move_y = $signed({1'b0, pos_y_q});
    case (dir_q)
      2'b00:   move_y = $signed({1'b0, pos_y_q}) - SP_S;
      2'b01:   move_x = $signed({1'b0, pos_x_q}) + SP_S;
      2'b10:   move_y = $signed({1'b0, pos_y_q}) + SP_S;
      default: move_x = $signed({1'b0, pos_x_q}) - SP_S;
    endcase
    move_ok = in_bounds(move_x, move_y);
  end

`ifdef MISSILE_COOLDOWN_EN
  localparam int CDW = $clog2(COOLDOWN_FRAMES + 1);
  logic [CDW-1:0] cooldown_q;
  assign fire_ok = (cooldown_q == '0);
`else
  assign fire_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      dir_q       <= 2'b00;
      active_q    <= 1'b0;
      explode_q   <= 1'b0;
      frame_cnt_q <= '0;
`ifdef MISSILE_COOLDOWN_EN
      cooldown_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (fire && spawn_ok && fire_ok) begin
            state_q  <= FLYING;
            pos_x_q  <= spawn_x[10:0];
            pos_y_q  <= spawn_y[10:0];
            dir_q    <= tankDir;
            active_q <= 1'b1;
          end
`ifdef MISSILE_COOLDOWN_EN
          if (startOfFrame && cooldown_q != '0)
            cooldown_q <= cooldown_q - 1'b1;
`endif
        end
        FLYING: begin
          // Collision outranks a same-cycle frame tick: the hit position is frozen.
          if (collision) begin
            state_q     <= EXPLODE;
            active_q    <= 1'b0;
            explode_q   <= 1'b1;
            frame_cnt_q <= '0;
          end else if (startOfFrame) begin
            if (move_ok) begin
              pos_x_q <= move_x[10:0];
              pos_y_q <= move_y[10:0];
            end else begin
              state_q  <= IDLE;
              active_q <= 1'b0;
`ifdef MISSILE_COOLDOWN_EN
              cooldown_q <= CDW'(COOLDOWN_FRAMES);
`endif
            end
          end
        end
        EXPLODE: begin
          if (startOfFrame) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            if (frame_cnt_q == FRAME_LAST) begin
              state_q   <= IDLE;
              explode_q <= 1'b0;
`ifdef MISSILE_COOLDOWN_EN
              cooldown_q <= CDW'(COOLDOWN_FRAMES);
`endif
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          active_q  <= 1'b0;
          explode_q <= 1'b0;
        end
      endcase
    end
  end

  assign topLeftX = pos_x_q;
  assign topLeftY = pos_y_q;
  assign dir      = dir_q;
  assign active   = active_q;
  assign explode  = explode_q;

endmodule

// File: tb/tb_missile_move_ctrl.sv
// tb/tb_missile_move_ctrl.sv - directed self-checking bench for missile_move_ctrl (default build).
module tb_missile_move_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        fire = 1'b0;
  logic [10:0] tankX = '0;
  logic [10:0] tankY = '0;
  logic [1:0]  tankDir = '0;
  logic        collision = 1'b0;
  logic [10:0] topLeftX, topLeftY;
  logic [1:0]  dir;
  logic        active, explode;

  int checks = 0;
  int errors = 0;

  missile_move_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fire(fire),
    .tankX(tankX), .tankY(tankY), .tankDir(tankDir), .collision(collision),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .dir(dir),
    .active(active), .explode(explode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shoot(input int x, input int y, input logic [1:0] d);
    tankX = 11'(x); tankY = 11'(y); tankDir = d; fire = 1'b1;
    step();
    fire = 1'b0;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  initial begin
    resetN = 1'b0;
    step(); step();
    chk("rst_x", 32'(topLeftX), 0);
    chk("rst_y", 32'(topLeftY), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_explode", 32'(explode), 0);
    resetN = 1'b1;
    step();

    // Fire right from (100,200)
    shoot(100, 200, 2'b01);
    chk("right_active", 32'(active), 1);
    chk("right_x", 32'(topLeftX), 132);
    chk("right_y", 32'(topLeftY), 212);
    chk("right_dir", 32'(dir), 1);

    // Fire while flying is ignored
    shoot(300, 300, 2'b10);
    chk("fly_refire_dir", 32'(dir), 1);
    chk("fly_refire_x", 32'(topLeftX), 132);

    // Collision and frame tick together: explode, no move
    collision = 1'b1; startOfFrame = 1'b1;
    step();
    collision = 1'b0; startOfFrame = 1'b0;
    chk("hit_explode", 32'(explode), 1);
    chk("hit_active", 32'(active), 0);
    chk("hit_x", 32'(topLeftX), 132);
    shoot(100, 200, 2'b00);
    chk("expl_fire_ignored", 32'(active), 0);
    for (int i = 0; i < 7; i++) sof();
    chk("expl_7_frames", 32'(explode), 1);
    sof();
    chk("expl_8_frames", 32'(explode), 0);
    chk("expl_done_active", 32'(active), 0);

    // Fire up from (100,200), three frames
    shoot(100, 200, 2'b00);
    chk("up_x", 32'(topLeftX), 112);
    chk("up_y0", 32'(topLeftY), 192);
    sof();
    chk("up_y1", 32'(topLeftY), 188);
    sof();
    chk("up_y2", 32'(topLeftY), 184);
    sof();
    chk("up_y3", 32'(topLeftY), 180);
    chk("up_active", 32'(active), 1);
    chk("up_x_hold", 32'(topLeftX), 112);

    // Asynchronous reset mid-flight clears outputs without a clock edge
    resetN = 1'b0;
    #2;
    chk("async_rst_active", 32'(active), 0);
    chk("async_rst_x", 32'(topLeftX), 0);
    chk("async_rst_y", 32'(topLeftY), 0);
    #1 resetN = 1'b1;
    step();

    // Right edge: spawn at 628, move to 632, next move exits
    shoot(596, 200, 2'b01);
    chk("edge_spawn_x", 32'(topLeftX), 628);
    sof();
    chk("edge_x_632", 32'(topLeftX), 632);
    chk("edge_active", 32'(active), 1);
    sof();
    chk("edge_exit_active", 32'(active), 0);
    chk("edge_exit_x", 32'(topLeftX), 632);
    chk("edge_exit_explode", 32'(explode), 0);

    // Illegal spawn to the left (x=-6) is ignored
    shoot(2, 50, 2'b11);
    chk("left_illegal_active", 32'(active), 0);
    step();
    chk("left_illegal_hold", 32'(active), 0);

    // Down spawn at bottom edge, then exit
    shoot(100, 440, 2'b10);
    chk("down_y", 32'(topLeftY), 472);
    chk("down_x", 32'(topLeftX), 112);
    chk("down_active", 32'(active), 1);
    sof();
    chk("down_exit_active", 32'(active), 0);
    chk("down_exit_y", 32'(topLeftY), 472);

    // Left spawn legal; collision ignored while idle afterwards
    shoot(50, 50, 2'b11);
    chk("left_x", 32'(topLeftX), 42);
    chk("left_y", 32'(topLeftY), 62);
    chk("left_dir", 32'(dir), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
